// File: rtl/cache_2way_burst.sv
// 2-way set-associative write-back/write-allocate cache with burst refill and burst write-back.
// Optional hit/miss counters are enabled by defining CACHE_PERF_CNT_EN.
module cache_2way_burst #(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 32,
  parameter int INDEX_W    = 6,
  parameter int LINE_WORDS = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ready,
  output logic              cpu_hit,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic [31:0]       hit_cnt,
  output logic [31:0]       miss_cnt
);

  localparam int OFF_W = $clog2(LINE_WORDS);
  localparam int TAG_W = ADDR_W - INDEX_W - OFF_W;
  localparam int SETS  = 1 << INDEX_W;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOOKUP = 3'd1;
  localparam logic [2:0] S_WB     = 3'd2;
  localparam logic [2:0] S_FILL   = 3'd3;
  localparam logic [2:0] S_RESP   = 3'd4;

  logic [2:0]              state;
  logic                    req_we;
  logic [ADDR_W-1:0]       req_addr;
  logic [DATA_W-1:0]       req_wdata;
  logic [OFF_W-1:0]        beat;
  logic                    vway;

  logic [1:0][SETS-1:0]    valid_q;
  logic [1:0][SETS-1:0]    dirty_q;
  logic [SETS-1:0]         lru_q;
  logic [TAG_W-1:0]        tag_mem  [2][SETS];
  logic [DATA_W-1:0]       data_mem [2][SETS*LINE_WORDS];

  logic [TAG_W-1:0]        req_tag;
  logic [INDEX_W-1:0]      req_idx;
  logic [OFF_W-1:0]        req_off;
  logic                    hit0, hit1, hit, hit_way, victim, victim_dirty, last_beat;
  logic [DATA_W-1:0]       fill_word;

  assign req_tag      = req_addr[ADDR_W-1 -: TAG_W];
  assign req_idx      = req_addr[OFF_W +: INDEX_W];
  assign req_off      = req_addr[OFF_W-1:0];
  assign hit0         = valid_q[0][req_idx] && (tag_mem[0][req_idx] == req_tag);
  assign hit1         = valid_q[1][req_idx] && (tag_mem[1][req_idx] == req_tag);
  assign hit          = hit0 || hit1;
  assign hit_way      = hit1;
  assign victim       = !valid_q[0][req_idx] ? 1'b0 :
                        !valid_q[1][req_idx] ? 1'b1 : lru_q[req_idx];
  assign victim_dirty = valid_q[victim][req_idx] && dirty_q[victim][req_idx];
  assign last_beat    = (beat == '1);
  // Store data is merged into the refill stream at the requested offset.
  assign fill_word    = (req_we && (beat == req_off)) ? req_wdata : mem_rdata;

  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (state)
      S_WB: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = {tag_mem[vway][req_idx], req_idx, beat};
        mem_wdata = data_mem[vway][{req_idx, beat}];
      end
      S_FILL: begin
        mem_req  = 1'b1;
        mem_addr = {req_tag, req_idx, beat};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      req_we    <= 1'b0;
      req_addr  <= '0;
      req_wdata <= '0;
      beat      <= '0;
      vway      <= 1'b0;
      valid_q   <= '0;
      dirty_q   <= '0;
      lru_q     <= '0;
      cpu_ready <= 1'b0;
      cpu_hit   <= 1'b0;
      cpu_rdata <= '0;
    end else begin
      cpu_ready <= 1'b0;
      case (state)
        S_IDLE: begin
          if (cpu_req) begin
            req_we    <= cpu_we;
            req_addr  <= cpu_addr;
            req_wdata <= cpu_wdata;
            state     <= S_LOOKUP;
          end
        end
        S_LOOKUP: begin
          cpu_hit <= hit;
          beat    <= '0;
          if (hit) begin
            cpu_rdata <= req_we ? '0 : data_mem[hit_way][{req_idx, req_off}];
            if (req_we) dirty_q[hit_way][req_idx] <= 1'b1;
            lru_q[req_idx] <= ~hit_way;
            state          <= S_RESP;
          end else begin
            // Victim is invalidated up front so an interrupted refill never looks valid.
            cpu_rdata                 <= '0;
            vway                      <= victim;
            valid_q[victim][req_idx]  <= 1'b0;
            state                     <= victim_dirty ? S_WB : S_FILL;
          end
        end
        S_WB: begin
          if (mem_ack) begin
            beat <= beat + 1'b1;
            if (last_beat) state <= S_FILL;
          end
        end
        S_FILL: begin
          if (mem_ack) begin
            beat <= beat + 1'b1;
            if (!req_we && (beat == req_off)) cpu_rdata <= mem_rdata;
            if (last_beat) begin
              valid_q[vway][req_idx] <= 1'b1;
              dirty_q[vway][req_idx] <= req_we;
              lru_q[req_idx]         <= ~vway;
              state                  <= S_RESP;
            end
          end
        end
        S_RESP: begin
          cpu_ready <= 1'b1;
          state     <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (state == S_LOOKUP && hit && req_we)
      data_mem[hit_way][{req_idx, req_off}] <= req_wdata;
    if (state == S_FILL && mem_ack) begin
      data_mem[vway][{req_idx, beat}] <= fill_word;
      if (last_beat) tag_mem[vway][req_idx] <= req_tag;
    end
  end

`ifdef CACHE_PERF_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else if (state == S_LOOKUP) begin
      if (hit) hit_cnt  <= hit_cnt + 32'd1;
      else     miss_cnt <= miss_cnt + 32'd1;
    end
  end
`else
  assign hit_cnt  = '0;
  assign miss_cnt = '0;
`endif

endmodule

// File: tb/tb_cache_2way_burst.sv
// Randomized self-checking bench for cache_2way_burst against a line-level cache model
// with a backing-memory array and an expected-beat queue per request.
module tb_cache_2way_burst;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_req, cpu_we;
  logic [15:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic        cpu_ready, cpu_hit;
  logic [31:0] cpu_rdata;
  logic        mem_req, mem_we;
  logic [15:0] mem_addr;
  logic [31:0] mem_wdata, mem_rdata;
  logic        mem_ack;
  logic [31:0] hit_cnt, miss_cnt;

  cache_2way_burst #(.ADDR_W(16), .DATA_W(32), .INDEX_W(6), .LINE_WORDS(4)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ready(cpu_ready), .cpu_hit(cpu_hit), .cpu_rdata(cpu_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
  );

  always #5 clk = ~clk;

  typedef struct { logic [15:0] addr; logic we; logic [31:0] data; } beat_t;
  typedef struct { bit valid; bit dirty; bit [7:0] tag; bit [3:0][31:0] w; } line_t;

  int          checks = 0;
  int          failures = 0;
  bit [31:0]   bmem [65536];
  line_t       mc [64][2];
  bit          lru [64];
  beat_t       exp_q [$];
  int          exp_hits, exp_misses;
  bit          rand_ack;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int s = 0; s < 64; s++) begin
      lru[s] = 1'b0;
      for (int w = 0; w < 2; w++) begin
        mc[s][w].valid = 1'b0;
        mc[s][w].dirty = 1'b0;
      end
    end
    exp_hits = 0;
    exp_misses = 0;
    exp_q.delete();
  endtask

  // Access semantics: hit updates LRU; miss evicts first invalid way else LRU way,
  // writes back a dirty victim, refills the line, then merges the store.
  task automatic model_access(input bit we, input bit [15:0] addr, input bit [31:0] wd,
                              output bit hit, output bit [31:0] rd);
    bit [7:0] tag = addr[15:8];
    int       idx = int'(addr[7:2]);
    int       off = int'(addr[1:0]);
    int       way = -1;
    for (int w = 0; w < 2; w++)
      if (mc[idx][w].valid && mc[idx][w].tag == tag) way = w;
    hit = (way >= 0);
    if (hit) begin
      exp_hits++;
      rd = we ? 32'd0 : mc[idx][way].w[off];
      if (we) begin
        mc[idx][way].w[off] = wd;
        mc[idx][way].dirty = 1'b1;
      end
      lru[idx] = (way == 0);
    end else begin
      exp_misses++;
      way = !mc[idx][0].valid ? 0 : !mc[idx][1].valid ? 1 : int'(lru[idx]);
      if (mc[idx][way].valid && mc[idx][way].dirty)
        for (int b = 0; b < 4; b++) begin
          beat_t e;
          e.addr = {mc[idx][way].tag, addr[7:2], 2'(b)};
          e.we = 1'b1;
          e.data = mc[idx][way].w[b];
          bmem[e.addr] = e.data;
          exp_q.push_back(e);
        end
      for (int b = 0; b < 4; b++) begin
        beat_t e;
        e.addr = {tag, addr[7:2], 2'(b)};
        e.we = 1'b0;
        e.data = 32'd0;
        mc[idx][way].w[b] = bmem[e.addr];
        exp_q.push_back(e);
      end
      if (we) mc[idx][way].w[off] = wd;
      mc[idx][way].valid = 1'b1;
      mc[idx][way].dirty = we;
      mc[idx][way].tag = tag;
      rd = we ? 32'd0 : mc[idx][way].w[off];
      lru[idx] = (way == 0);
    end
  endtask

  task automatic do_req(input bit we, input bit [15:0] addr, input bit [31:0] wd,
                        input int stall_beat, input int stall_len, input int abort_after);
    bit        ehit;
    bit [31:0] erd;
    int        beats = 0, stalls = 0, stall_cnt = 0;
    bit        done = 1'b0, ack;
    beat_t     h;
    model_access(we, addr, wd, ehit, erd);
    @(negedge clk);
    check("ready_pulse", 32'(cpu_ready), 32'd0);
    cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wd; mem_ack = 1'b0;
    @(negedge clk);
    cpu_req = 1'b0; cpu_we = 1'($urandom); cpu_addr = 16'($urandom); cpu_wdata = $urandom;
    for (int cyc = 1; cyc <= 300 && !done; cyc++) begin
      @(negedge clk);
      if (cpu_ready) begin
        check("latency", 32'(cyc), 32'(2 + beats + stalls));
        check("cpu_hit", 32'(cpu_hit), 32'(ehit));
        check("cpu_rdata", cpu_rdata, erd);
        check("beats_left", 32'(exp_q.size()), 32'd0);
`ifdef CACHE_PERF_CNT_EN
        check("hit_cnt", hit_cnt, 32'(exp_hits));
        check("miss_cnt", miss_cnt, 32'(exp_misses));
`else
        check("hit_cnt", hit_cnt, 32'd0);
        check("miss_cnt", miss_cnt, 32'd0);
`endif
        mem_ack = 1'b0;
        done = 1'b1;
      end else if (abort_after >= 0 && beats == abort_after) begin
        rst = 1'b1;
        #1;
        check("rst_mem_req", 32'(mem_req), 32'd0);
        check("rst_ready", 32'(cpu_ready), 32'd0);
        mem_ack = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        done = 1'b1;
      end else begin
        check("mem_req", 32'(mem_req), 32'(exp_q.size() != 0));
        if (mem_req && exp_q.size() != 0) begin
          h = exp_q[0];
          check("mem_addr", 32'(mem_addr), 32'(h.addr));
          check("mem_we", 32'(mem_we), 32'(h.we));
          if (h.we) check("mem_wdata", mem_wdata, h.data);
          if (beats == stall_beat && stall_cnt < stall_len) begin
            ack = 1'b0;
            stall_cnt++;
          end else begin
            ack = rand_ack ? ($urandom_range(0, 3) != 0) : 1'b1;
          end
          if (ack) begin
            mem_rdata = bmem[mem_addr];
            void'(exp_q.pop_front());
            beats++;
          end else begin
            mem_rdata = $urandom;
            stalls++;
          end
          mem_ack = ack;
        end else begin
          mem_ack = 1'($urandom);
          mem_rdata = $urandom;
        end
      end
    end
    if (!done) begin
      check("timeout", 32'd0, 32'd1);
      exp_q.delete();
    end
  endtask

  initial begin
    bit [7:0] tags [4] = '{8'h12, 8'h22, 8'h32, 8'h42};
    bit [5:0] idxs [3] = '{6'h0D, 6'h0E, 6'h21};
    for (int i = 0; i < 65536; i++) bmem[i] = 32'(i) * 32'h9E3779B1 ^ 32'h5A5A0000;
    for (int i = 0; i < 4; i++) bmem[16'h1234 + i] = 32'hA0 + 32'(i);
    rst = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    mem_ack = 1'b0; mem_rdata = '0; rand_ack = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check("rst_cpu_ready", 32'(cpu_ready), 32'd0);
    check("rst_cpu_hit", 32'(cpu_hit), 32'd0);
    check("rst_cpu_rdata", cpu_rdata, 32'd0);
    check("rst_mem_req0", 32'(mem_req), 32'd0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    check("rst_hit_cnt", hit_cnt, 32'd0);
    check("rst_miss_cnt", miss_cnt, 32'd0);
    rst = 1'b0;

    do_req(1'b0, 16'h1234, 32'd0, -1, 0, -1);
    do_req(1'b0, 16'h1236, 32'd0, -1, 0, -1);
    do_req(1'b1, 16'h1235, 32'hDEADBEEF, -1, 0, -1);
    do_req(1'b0, 16'h1235, 32'd0, -1, 0, -1);
    do_req(1'b0, 16'h2234, 32'd0, -1, 0, -1);
    do_req(1'b0, 16'h3234, 32'd0, 2, 5, -1);
    do_req(1'b0, 16'h1234, 32'd0, 6, 5, -1);

    rand_ack = 1'b1;
    for (int n = 0; n < 250; n++) begin
      bit [15:0] a;
      a[15:8] = ($urandom_range(0, 4) == 4) ? 8'($urandom) : tags[$urandom_range(0, 3)];
      a[7:2]  = ($urandom_range(0, 3) == 3) ? 6'($urandom) : idxs[$urandom_range(0, 2)];
      a[1:0]  = 2'($urandom);
      do_req(1'($urandom), a, $urandom, -1, 0, -1);
    end

    rand_ack = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    do_req(1'b0, 16'h1234, 32'd0, -1, 0, 2);
    do_req(1'b0, 16'h1234, 32'd0, -1, 0, -1);
    do_req(1'b0, 16'h1237, 32'd0, -1, 0, -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cache_2way_burst.md
# cache_2way_burst

Parametrised 2-way set-associative, write-back, write-allocate cache sitting between the CPU port and the backing memory in the CACHE subsystem. It generalises the single-word cache to configurable address width, set count and multi-word lines. Misses are served by burst refill, and dirty victims are written back with a per-beat ack handshake. Optional hit/miss performance counters are included.

## Interface
- ADDR_W, 16, word address width (addresses are word-granular; no byte offset)
- DATA_W, 32, word width
- INDEX_W, 6, set index bits (2^INDEX_W sets)
- LINE_WORDS, 4, words per line; power of two, ≥2; OFF_W = log2(LINE_WORDS), TAG_W = ADDR_W-INDEX_W-OFF_W
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- cpu_req  in  1  request; sampled only in IDLE
- cpu_we  in  1  1 = write, 0 = read; captured with cpu_req
- cpu_addr  in  ADDR_W  request address: tag | index | offset (MSB→LSB)
- cpu_wdata  in  DATA_W  store data
- cpu_ready  out  1  one-cycle completion pulse
- cpu_hit  out  1  valid with cpu_ready; 1 = request hit on lookup
- cpu_rdata  out  DATA_W  read data, valid with cpu_ready; 0 for writes
- mem_req  out  1  burst active; held until last beat acked
- mem_we  out  1  1 = write-back burst, 0 = refill burst
- mem_addr  out  ADDR_W  current beat address = line base + beat count
- mem_wdata  out  DATA_W  write-back word for current beat
- mem_rdata  in  DATA_W  refill word, valid when mem_ack=1
- mem_ack  in  1  beat accepted/returned this cycle
- hit_cnt  out  32  hits since reset (see Configuration)
- miss_cnt  out  32  misses since reset (see Configuration)

## Operation
- Per set: valid[2], dirty[2], tag[2], one lru bit naming the way to evict. Per line: LINE_WORDS data words.
- FSM states:
  - IDLE: on cpu_req, register we/addr/wdata → LOOKUP.
  - LOOKUP: tag compare on both ways.
    - Hit: read returns the word; write updates the word and sets dirty. lru ← other way. → RESP.
    - Miss, victim clean: → FILL. Victim dirty: → WB.
- Victim selection: first invalid way, way 0 preferred; otherwise the way named by lru.
- WB: mem_req=1, mem_we=1, mem_addr={victim tag, index, beat}, mem_wdata=victim word[beat]. Beat advances on mem_ack. On the last beat → FILL.
- FILL: mem_req=1, mem_we=0, mem_addr={req tag, index, beat}. Each acked mem_rdata is written into victim word[beat]. On the last beat:
  - tag/valid are set.
  - For a write: the cpu_wdata word is merged at the request offset and dirty=1. For a read: dirty=0.
  - cpu_rdata ← requested word.
  - lru ← other way.
  - → RESP.
- RESP: cpu_ready=1 for one cycle → IDLE. The CPU must drop or replace cpu_req by this cycle; cpu_req high in the following IDLE is a new request.
- Requests arriving outside IDLE are ignored. Capture happens in IDLE, so cpu_* may change after capture.
- Reset values: cpu_ready=0, cpu_hit=0, cpu_rdata=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, counters=0, state IDLE, beat=0. All valid/dirty/lru are cleared. Tag and data arrays are not reset.
- Reset mid-burst: mem_req drops asynchronously and the partial line stays invalid.

## Timing
- Hit: cpu_req sampled at edge E0; cpu_ready high in the cycle after edge E2, i.e. 2 cycles after capture.
- Clean miss: 2 + LINE_WORDS acked beats + stalls.
- Dirty miss: 2 + 2·LINE_WORDS acked beats + stalls.
- No idle cycle is inserted between the WB and FILL bursts.
- mem_ack low holds mem_addr/mem_wdata/mem_we stable. mem_ack is ignored when mem_req=0.
- Counters update at the LOOKUP→next edge: hits in LOOKUP, misses in LOOKUP. Counters wrap at 2^32.

## Configuration
- CACHE_PERF_CNT_EN defined: hit_cnt and miss_cnt count as above.
- Not defined: counter logic is omitted and hit_cnt=miss_cnt=0 constantly. All other behaviour is identical.

## Test plan
All scenarios use default parameters (TAG_W=8): address 0x1234 → tag 0x12, index 0x0D, offset 0.
- Cold read miss: after reset, read 0x1234 with memory data 0xA0..0xA3 for 0x1234..0x1237.
  - Expect 4 refill beats, mem_addr 0x1234→0x1237, mem_we=0.
  - Expect cpu_rdata=0xA0, cpu_hit=0, miss_cnt=1.
- Read hit: read 0x1236 → cpu_ready 2 cycles after capture, cpu_rdata=0xA2, cpu_hit=1, mem_req stays 0, hit_cnt=1.
- Write hit, then readback: write 0x1235=0xDEADBEEF, then read 0x1235.
  - Expect readback 0xDEADBEEF and no mem_req.
  - The line is now dirty.
- Eviction with write-back: read 0x2234 (fills way 1), then read 0x3234 (evicts way 0, the dirty line).
  - Expect WB beats at 0x1234..0x1237 with data 0xA0, 0xDEADBEEF, 0xA2, 0xA3.
  - Then refill at 0x3234..0x3237.
- Memory stall: mem_ack held low 5 cycles between beats 1 and 2 → mem_addr/mem_wdata stable, no beat skipped or duplicated.
- Reset mid-fill: assert rst after 2 acked refill beats.
  - mem_req=0 in the same cycle.
  - A subsequent read of 0x1234 misses.
  - With the macro undefined, hit_cnt=miss_cnt=0 throughout.
